// File: rtl/chacha_pkg.sv
// Shared ChaCha20 definitions: word type, quarter-round word-index table,
// step/op encodings and the "expand 32-byte k" constants.
package chacha_pkg;

    typedef logic [31:0] chacha_word_t;

    // Rows 0..3 are column quarter-rounds, rows 4..7 diagonal quarter-rounds; entries are a,b,c,d.
    localparam logic [3:0] QR_IDX [8][4] = '{
        '{4'd0, 4'd4, 4'd8,  4'd12},
        '{4'd1, 4'd5, 4'd9,  4'd13},
        '{4'd2, 4'd6, 4'd10, 4'd14},
        '{4'd3, 4'd7, 4'd11, 4'd15},
        '{4'd0, 4'd5, 4'd10, 4'd15},
        '{4'd1, 4'd6, 4'd11, 4'd12},
        '{4'd2, 4'd7, 4'd8,  4'd13},
        '{4'd3, 4'd4, 4'd9,  4'd14}
    };

    localparam logic [1:0] STEP_AD0 = 2'd0;
    localparam logic [1:0] STEP_BC0 = 2'd1;
    localparam logic [1:0] STEP_AD1 = 2'd2;
    localparam logic [1:0] STEP_BC1 = 2'd3;

    localparam logic [3:0] OP_AD0 = 4'b0001;
    localparam logic [3:0] OP_BC0 = 4'b0010;
    localparam logic [3:0] OP_AD1 = 4'b0100;
    localparam logic [3:0] OP_BC1 = 4'b1000;

    localparam chacha_word_t CHACHA_CONST0 = 32'h6170_7865;
    localparam chacha_word_t CHACHA_CONST1 = 32'h3320_646e;
    localparam chacha_word_t CHACHA_CONST2 = 32'h7962_2d32;
    localparam chacha_word_t CHACHA_CONST3 = 32'h6b20_6574;

    function automatic chacha_word_t rotl32(input chacha_word_t x, input int unsigned n);
        return (x << n) | (x >> (32 - n));
    endfunction

endpackage

// File: rtl/chacha20_block_seq_schacha20.sv
// Combinational schacha20 quarter-round step: rs1={a,d}, rs2={b,c}; ad ops
// return {a',d'}, bc ops return {b',c'}.
module chacha20_block_seq_schacha20
    import chacha_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [63:0] rs1,
    input  logic [63:0] rs2,
    output logic [63:0] rd
);

    chacha_word_t a, b, c, d;
    chacha_word_t sum_ad, sum_bc, mix_d, mix_b;

    assign a = rs1[63:32];
    assign d = rs1[31:0];
    assign b = rs2[63:32];
    assign c = rs2[31:0];

    assign sum_ad = a + b;
    assign mix_d  = d ^ sum_ad;
    assign sum_bc = c + d;
    assign mix_b  = b ^ sum_bc;

    always_comb begin
        rd = '0;
        unique case (op)
            OP_AD0:  rd = {sum_ad, rotl32(mix_d, 16)};
            OP_BC0:  rd = {rotl32(mix_b, 12), sum_bc};
            OP_AD1:  rd = {sum_ad, rotl32(mix_d, 8)};
            OP_BC1:  rd = {rotl32(mix_b, 7), sum_bc};
            default: rd = '0;
        endcase
    end

endmodule

// File: rtl/chacha20_block_seq.sv
// Iterative ChaCha20 block engine: one quarter-round step per cycle, 16*ROUNDS cycles per block.
// Define CHACHA_FEEDFWD_EN to add the init register and output work+init (RFC 8439 keystream).
//
// state | meaning
// IDLE  | waiting for i_valid, i_ready=1
// RUN   | one schacha20 op per cycle
// DONE  | result on o_state, o_valid=1 until o_ready
module chacha20_block_seq
    import chacha_pkg::*;
#(
    parameter int ROUNDS = 20
) (
    input  logic         g_clk,
    input  logic         g_resetn,
    input  logic         i_valid,
    output logic         i_ready,
    input  logic [511:0] i_state,
    output logic         o_valid,
    input  logic         o_ready,
    output logic [511:0] o_state,
    output logic         busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int DR_LAST = ROUNDS / 2 - 1;
    localparam int DR_W    = (ROUNDS / 2 > 1) ? $clog2(ROUNDS / 2) : 1;

    logic [1:0]      state;
    logic [1:0]      step;
    logic [2:0]      qr;
    logic [DR_W-1:0] dr;
    chacha_word_t    work [16];
`ifdef CHACHA_FEEDFWD_EN
    chacha_word_t    init [16];
`endif

    logic        accept;
    logic        last_op;
    logic [3:0]  idx_a, idx_b, idx_c, idx_d;
    logic [3:0]  op;
    logic [63:0] rs1, rs2, rd;

    assign accept  = (state == ST_IDLE) && i_valid;
    assign last_op = (dr == DR_W'(DR_LAST)) && (qr == 3'd7) && (step == STEP_BC1);

    assign idx_a = QR_IDX[qr][0];
    assign idx_b = QR_IDX[qr][1];
    assign idx_c = QR_IDX[qr][2];
    assign idx_d = QR_IDX[qr][3];

    assign op  = 4'b0001 << step;
    assign rs1 = {work[idx_a], work[idx_d]};
    assign rs2 = {work[idx_b], work[idx_c]};

    chacha20_block_seq_schacha20 u_schacha20 (
        .op  (op),
        .rs1 (rs1),
        .rs2 (rs2),
        .rd  (rd)
    );

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state <= ST_IDLE;
            step  <= '0;
            qr    <= '0;
            dr    <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state <= ST_RUN;
                        step  <= '0;
                        qr    <= '0;
                        dr    <= '0;
                    end
                end
                ST_RUN: begin
                    step <= step + 2'd1;
                    if (step == STEP_BC1) begin
                        qr <= qr + 3'd1;
                        if (qr == 3'd7) begin
                            dr <= last_op ? '0 : dr + 1'b1;
                        end
                    end
                    if (last_op) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (o_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // ad steps update words a and d, bc steps update b and c; the four indices never collide.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            for (int i = 0; i < 16; i++) begin
                work[i] <= '0;
            end
        end else if (accept) begin
            for (int i = 0; i < 16; i++) begin
                work[i] <= i_state[32*i +: 32];
            end
        end else if (state == ST_RUN) begin
            if (!step[0]) begin
                work[idx_a] <= rd[63:32];
                work[idx_d] <= rd[31:0];
            end else begin
                work[idx_b] <= rd[63:32];
                work[idx_c] <= rd[31:0];
            end
        end
    end

`ifdef CHACHA_FEEDFWD_EN
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            for (int i = 0; i < 16; i++) begin
                init[i] <= '0;
            end
        end else if (accept) begin
            for (int i = 0; i < 16; i++) begin
                init[i] <= i_state[32*i +: 32];
            end
        end
    end
`endif

    always_comb begin
        o_state = '0;
        if (state == ST_DONE) begin
            for (int i = 0; i < 16; i++) begin
`ifdef CHACHA_FEEDFWD_EN
                o_state[32*i +: 32] = work[i] + init[i];
`else
                o_state[32*i +: 32] = work[i];
`endif
            end
        end
    end

    assign i_ready = (state == ST_IDLE);
    assign o_valid = (state == ST_DONE);
    assign busy    = (state == ST_RUN) || (state == ST_DONE);

endmodule

// File: tb/tb_chacha20_block_seq.sv
// Self-checking bench for chacha20_block_seq (ROUNDS=20 and ROUNDS=8 instances)
// against a word-array ChaCha reference model.
module tb_chacha20_block_seq;

    logic         g_clk;
    logic         g_resetn;
    logic         i_valid, i_ready, o_valid, o_ready, busy;
    logic [511:0] i_state, o_state;
    logic         i_valid8, i_ready8, o_valid8, o_ready8, busy8;
    logic [511:0] i_state8, o_state8;

    int total = 0;
    int bad   = 0;

`ifdef CHACHA_FEEDFWD_EN
    localparam bit FF = 1'b1;
`else
    localparam bit FF = 1'b0;
`endif

    chacha20_block_seq #(.ROUNDS(20)) dut (
        .g_clk(g_clk), .g_resetn(g_resetn),
        .i_valid(i_valid), .i_ready(i_ready), .i_state(i_state),
        .o_valid(o_valid), .o_ready(o_ready), .o_state(o_state),
        .busy(busy)
    );

    chacha20_block_seq #(.ROUNDS(8)) dut8 (
        .g_clk(g_clk), .g_resetn(g_resetn),
        .i_valid(i_valid8), .i_ready(i_ready8), .i_state(i_state8),
        .o_valid(o_valid8), .o_ready(o_ready8), .o_state(o_state8),
        .busy(busy8)
    );

    initial g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Plain ChaCha: even rounds on columns, odd rounds on diagonals.
    function automatic logic [511:0] chacha_ref(input logic [511:0] in, input int rounds, input bit ff);
        logic [31:0]  x [16];
        logic [31:0]  a, b, c, d;
        int           idx [4];
        logic [511:0] out;
        for (int i = 0; i < 16; i++) x[i] = in[32*i +: 32];
        for (int r = 0; r < rounds; r++) begin
            for (int j = 0; j < 4; j++) begin
                if (r % 2 == 0) idx = '{j, j + 4, j + 8, j + 12};
                else            idx = '{j, 4 + (j + 1) % 4, 8 + (j + 2) % 4, 12 + (j + 3) % 4};
                a = x[idx[0]]; b = x[idx[1]]; c = x[idx[2]]; d = x[idx[3]];
                a = a + b; d = d ^ a; d = {d[15:0], d[31:16]};
                c = c + d; b = b ^ c; b = {b[19:0], b[31:20]};
                a = a + b; d = d ^ a; d = {d[23:0], d[31:24]};
                c = c + d; b = b ^ c; b = {b[24:0], b[31:25]};
                x[idx[0]] = a; x[idx[1]] = b; x[idx[2]] = c; x[idx[3]] = d;
            end
        end
        for (int i = 0; i < 16; i++) out[32*i +: 32] = x[i] + (ff ? in[32*i +: 32] : 32'h0);
        return out;
    endfunction

    function automatic logic [511:0] rand_state();
        logic [511:0] s;
        for (int i = 0; i < 16; i++) s[32*i +: 32] = $urandom;
        s[31:0] = 32'h6170_7865;
        return s;
    endfunction

    // Offers st, optionally injects a second offer at op inject_at, waits for o_valid (bounded).
    task automatic run20(input logic [511:0] st, input int inject_at, input logic [511:0] other,
                         output logic [511:0] res, output int lat);
        @(negedge g_clk);
        i_valid = 1'b1;
        i_state = st;
        @(posedge g_clk);
        @(negedge g_clk);
        i_valid = 1'b0;
        i_state = ~st;
        lat = 0;
        while (!o_valid && lat < 2000) begin
            @(posedge g_clk);
            lat++;
            @(negedge g_clk);
            if (inject_at > 0 && lat == inject_at) begin
                i_valid = 1'b1;
                i_state = other;
            end
            if (inject_at > 0 && lat > inject_at && lat <= inject_at + 5) begin
                check("busy_ignore_i_ready", i_ready, 1'b0);
                if (lat == inject_at + 5) i_valid = 1'b0;
            end
        end
        res = o_state;
    endtask

    task automatic release20();
        o_ready = 1'b1;
        @(posedge g_clk);
        @(negedge g_clk);
        o_ready = 1'b0;
        check("release_i_ready", i_ready, 1'b1);
        check("release_o_valid", o_valid, 1'b0);
    endtask

    logic [511:0] rfc, res, held, st_a, st_b, exp;
    int           lat, seen;

    initial begin
        rfc = '0;
        rfc[32*0 +: 32]  = 32'h6170_7865; rfc[32*1 +: 32]  = 32'h3320_646e;
        rfc[32*2 +: 32]  = 32'h7962_2d32; rfc[32*3 +: 32]  = 32'h6b20_6574;
        rfc[32*4 +: 32]  = 32'h0302_0100; rfc[32*5 +: 32]  = 32'h0706_0504;
        rfc[32*6 +: 32]  = 32'h0b0a_0908; rfc[32*7 +: 32]  = 32'h0f0e_0d0c;
        rfc[32*8 +: 32]  = 32'h1312_1110; rfc[32*9 +: 32]  = 32'h1716_1514;
        rfc[32*10 +: 32] = 32'h1b1a_1918; rfc[32*11 +: 32] = 32'h1f1e_1d1c;
        rfc[32*12 +: 32] = 32'h0000_0001; rfc[32*13 +: 32] = 32'h0900_0000;
        rfc[32*14 +: 32] = 32'h4a00_0000; rfc[32*15 +: 32] = 32'h0000_0000;

        g_resetn = 1'b0;
        i_valid  = 1'b1;  i_state  = rand_state(); o_ready  = 1'b0;
        i_valid8 = 1'b0;  i_state8 = '0;           o_ready8 = 1'b0;
        repeat (3) @(negedge g_clk);
        check("reset_i_ready", i_ready, 1'b1);
        check("reset_o_valid", o_valid, 1'b0);
        check("reset_busy",    busy,    1'b0);
        check("reset_o_state", o_state, '0);
        i_valid  = 1'b0;
        g_resetn = 1'b1;
        @(negedge g_clk);

        // RFC 8439 block vector
        run20(rfc, 0, '0, res, lat);
        check("rfc_latency", lat, 320);
        if (FF) begin
            check("rfc_word0",  res[31:0],    32'he4e7_f110);
            check("rfc_word15", res[511:480], 32'h4e3c_50a2);
        end else begin
            check("rfc_word0_raw", res[31:0], 32'h8377_78ab);
        end
        check("rfc_full", res, chacha_ref(rfc, 20, FF));
        release20();

        // Backpressure: result held while o_ready=0; offered reload on release edge is not taken
        st_a = rand_state();
        run20(st_a, 0, '0, held, lat);
        check("bp_latency", lat, 320);
        check("bp_result", held, chacha_ref(st_a, 20, FF));
        for (int k = 0; k < 10; k++) begin
            @(negedge g_clk);
            check("bp_o_state", o_state, held);
            check("bp_o_valid", o_valid, 1'b1);
            check("bp_i_ready", i_ready, 1'b0);
        end
        i_valid = 1'b1;
        i_state = rand_state();
        release20();
        i_valid = 1'b0;
        check("bp_no_same_cycle_reload", busy, 1'b0);

        // Busy ignore: second offer during RUN has no effect
        st_a = rand_state();
        st_b = rand_state();
        run20(st_a, 100, st_b, res, lat);
        check("ignore_latency", lat, 320);
        check("ignore_result", res, chacha_ref(st_a, 20, FF));
        release20();

        // Random blocks
        for (int n = 0; n < 3; n++) begin
            st_a = rand_state();
            run20(st_a, 0, '0, res, lat);
            check("rand_latency", lat, 320);
            check("rand_result", res, chacha_ref(st_a, 20, FF));
            release20();
        end

        // Reset mid-run at op 150
        @(negedge g_clk);
        i_valid = 1'b1;
        i_state = rand_state();
        @(posedge g_clk);
        @(negedge g_clk);
        i_valid = 1'b0;
        repeat (149) @(posedge g_clk);
        @(negedge g_clk);
        check("midrun_busy_before", busy, 1'b1);
        g_resetn = 1'b0;
        #1;
        check("midrun_i_ready", i_ready, 1'b1);
        check("midrun_o_valid", o_valid, 1'b0);
        check("midrun_busy",    busy,    1'b0);
        check("midrun_o_state", o_state, '0);
        @(negedge g_clk);
        g_resetn = 1'b1;
        seen = 0;
        for (int k = 0; k < 400; k++) begin
            @(negedge g_clk);
            if (o_valid || busy) seen++;
        end
        check("midrun_no_partial", seen, 0);
        run20(rfc, 0, '0, res, lat);
        check("post_reset_latency", lat, 320);
        check("post_reset_rfc", res, chacha_ref(rfc, 20, FF));
        release20();

        // ROUNDS=8 instance
        st_a = rand_state();
        @(negedge g_clk);
        i_valid8 = 1'b1;
        i_state8 = st_a;
        @(posedge g_clk);
        @(negedge g_clk);
        i_valid8 = 1'b0;
        i_state8 = '0;
        lat = 0;
        while (!o_valid8 && lat < 2000) begin
            @(posedge g_clk);
            lat++;
            @(negedge g_clk);
        end
        check("r8_latency", lat, 128);
        exp = chacha_ref(st_a, 8, FF);
        check("r8_result", o_state8, exp);
        o_ready8 = 1'b1;
        @(posedge g_clk);
        @(negedge g_clk);
        o_ready8 = 1'b0;
        check("r8_release_i_ready", i_ready8, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
